rx_lock_ctrl: RTL and testbench
===============================

# rx_lock_ctrl

Block-lock controller for the receive gearbox path. Sequences the 22-way header seeker: holds it in reset, waits for its offset output to settle, commits that offset to the block slicer, verifies framing on the sliced headers, and declares lock. Once locked it monitors the header error rate and restarts the seeker on loss of lock. Sits between the seeker, the gearbox buffer logic and the 66b block slicer/descrambler.

## Interface
- STABLE_DV, default 16: consecutive identical seeker offsets (on buffer_dv_i) required before commit
- SETTLE_TO, default 1023: buffer_dv_i strobes allowed in SETTLE before restart
- VERIFY_CNT, default 32: consecutive good headers required to lock
- WIN_LEN, default 64: header window length while locked
- BAD_MAX, default 8: bad headers within one window that force relock
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- buffer_dv_i  in  1  gearbox buffer valid strobe (same strobe the seeker uses)
- seek_offset_i  in  7  seeker candidate header offset
- hdr_i  in  2  header bits of the block sliced at offset_o
- hdr_dv_i  in  1  hdr_i valid
- seeker_rst_o  out  1  reset to the seeker
- offset_o  out  7  committed block offset to the slicer
- locked_o  out  1  block lock
- relock_cnt_o  out  16  loss-of-lock counter (see Configuration)

## Operation
- Good header: hdr_i == 2'b01 or 2'b10; anything else bad. hdr_i ignored when hdr_dv_i = 0.
- States: SEEK_RST, SETTLE, VERIFY, LOCKED.
- SEEK_RST: seeker_rst_o = 1; clear stable/timeout/good/window/bad counters; next cycle SETTLE unconditionally.
- SETTLE: on each buffer_dv_i: if seek_offset_i == prev and seek_offset_i <= 65, stable_cnt++, else stable_cnt = 0; prev <= seek_offset_i; timeout_cnt++. When stable_cnt reaches STABLE_DV-1 on a strobe with a matching offset: offset_o <= seek_offset_i, go VERIFY. Else when timeout_cnt reaches SETTLE_TO: go SEEK_RST. Commit takes priority over timeout on the same strobe.
- VERIFY: good header: good_cnt++; good_cnt reaching VERIFY_CNT goes LOCKED (locked_o = 1 from next cycle). Any bad header goes SEEK_RST.
- LOCKED: each valid header increments win_cnt; bad headers increment bad_cnt. If a bad header makes bad_cnt == BAD_MAX, go SEEK_RST and increment relock. On the last header of a window (win_cnt == WIN_LEN-1), evaluate it into the current window first, then clear win_cnt and bad_cnt.
- offset_o holds its last committed value outside SETTLE→VERIFY commits, including through SEEK_RST.
- Counters saturate and never wrap; relock counter saturates at 16'hFFFF.

## Timing
- Reset (async assert): state = SEEK_RST, seeker_rst_o = 1, offset_o = 0, locked_o = 0, relock_cnt_o = 0, all counters 0.
- After deassertion, first rising edge moves to SETTLE. seeker_rst_o is high only during reset plus exactly one cycle per SEEK_RST entry.
- All outputs registered or decoded directly from the state register; no input-to-output combinational path.
- locked_o falls in the same cycle seeker_rst_o rises.
- Minimum time to lock from reset release: 1 + STABLE_DV buffer_dv_i strobes + VERIFY_CNT headers, plus 1 cycle.
- Reset asserted mid-operation: immediate return to reset values, in any state.

## Configuration
- RX_LOCK_CTRL_STATS_EN defined: relock_cnt_o counts LOCKED→SEEK_RST transitions, saturating at 16'hFFFF; cleared only by rst_i.
- Not defined: no counter register; relock_cnt_o tied to 16'h0000. All other behaviour is identical.

## Test plan
- Reset: assert rst_i mid-LOCKED. Response: locked_o = 0 and seeker_rst_o = 1 asynchronously, offset_o = 0, relock_cnt_o = 0. After release, exactly 1 cycle of seeker_rst_o.
- Clean lock: seek_offset_i = 37 for 16 strobes, then 32 headers of 2'b01. Response: offset_o = 37 after the 16th strobe; locked_o rises after the 32nd header.
- Unstable seeker: seek_offset_i alternates 12/13 for 1023 strobes. Response: no commit; SEEK_RST entered (seeker_rst_o pulse) at strobe 1023. Offset 70 held constant also never commits.
- VERIFY failure: lock sequence, but header 20 = 2'b00. Response: seeker_rst_o pulse, locked_o stays 0, relock_cnt_o unchanged.
- Loss of lock: once locked, 7 bad headers in a 64-header window; then the next window has 8 bad headers. Response: lock is kept through the first window. On the 8th bad header of the second window, locked_o falls and relock_cnt_o = 1 (0 with the macro undefined).
- Boundary: the 8th bad header is the 64th header of a window. Response: unlock. With 7 bad headers, the bad header on the 64th header clears the window counters and lock is kept.

Source files
------------

// File: rtl/rx_lock_ctrl.sv
// ============================================================================
// rx_lock_ctrl : block-lock sequencer for the 66b receive gearbox path
// Define RX_LOCK_CTRL_STATS_EN to enable the loss-of-lock counter. Rev 1.0
// ============================================================================
`default_nettype none

module rx_lock_ctrl #(
   parameter int STABLE_DV  = 16,
   parameter int SETTLE_TO  = 1023,
   parameter int VERIFY_CNT = 32,
   parameter int WIN_LEN    = 64,
   parameter int BAD_MAX    = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        buffer_dv_i,
   input  logic [6:0]  seek_offset_i,
   input  logic [1:0]  hdr_i,
   input  logic        hdr_dv_i,
   output logic        seeker_rst_o,
   output logic [6:0]  offset_o,
   output logic        locked_o,
   output logic [15:0] relock_cnt_o
);

   localparam int SW = $clog2(STABLE_DV + 1);
   localparam int TW = $clog2(SETTLE_TO + 1);
   localparam int GW = $clog2(VERIFY_CNT + 1);
   localparam int WW = $clog2(WIN_LEN + 1);
   localparam int BW = $clog2(BAD_MAX + 1);

   // "_PRE" values: the count held just before the strobe/header that completes it
   localparam logic [SW-1:0] STABLE_PRE = SW'(STABLE_DV - 2);
   localparam logic [TW-1:0] TO_PRE     = TW'(SETTLE_TO - 1);
   localparam logic [GW-1:0] GOOD_PRE   = GW'(VERIFY_CNT - 1);
   localparam logic [WW-1:0] WIN_PRE    = WW'(WIN_LEN - 1);
   localparam logic [BW-1:0] BAD_PRE    = BW'(BAD_MAX - 1);
   localparam logic [6:0]    MAX_OFFSET = 7'd65;

   typedef enum logic [1:0] {
      SEEK_RST = 2'd0,
      SETTLE   = 2'd1,
      VERIFY   = 2'd2,
      LOCKED   = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [6:0]    prev_offset;
   logic [SW-1:0] stable_cnt;
   logic [TW-1:0] timeout_cnt;
   logic [GW-1:0] good_cnt;
   logic [WW-1:0] win_cnt;
   logic [BW-1:0] bad_cnt;

   logic          hdr_good;
   logic          hdr_bad;
   logic          off_match;
   logic          stable_done;
   logic          commit;
   logic          settle_timeout;
   logic          verify_done;
   logic          verify_fail;
   logic          lose_lock;
   logic          win_last;

   assign hdr_good    = hdr_dv_i && ((hdr_i == 2'b01) || (hdr_i == 2'b10));
   assign hdr_bad     = hdr_dv_i && !((hdr_i == 2'b01) || (hdr_i == 2'b10));
   assign off_match   = (seek_offset_i == prev_offset) && (seek_offset_i <= MAX_OFFSET);
   assign stable_done = (STABLE_DV < 2) || (stable_cnt == STABLE_PRE);

   // Commit wins over timeout when both land on the same strobe
   assign commit         = (state == SETTLE) && buffer_dv_i && off_match && stable_done;
   assign settle_timeout = (state == SETTLE) && buffer_dv_i && !commit && (timeout_cnt == TO_PRE);
   assign verify_done    = (state == VERIFY) && hdr_good && (good_cnt == GOOD_PRE);
   assign verify_fail    = (state == VERIFY) && hdr_bad;
   assign lose_lock      = (state == LOCKED) && hdr_bad && (bad_cnt == BAD_PRE);
   assign win_last       = (win_cnt == WIN_PRE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= SEEK_RST;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      seeker_rst_o = 1'b0;
      locked_o     = 1'b0;
      case (state)
         SEEK_RST: begin
            seeker_rst_o = 1'b1;
            state_nxt    = SETTLE;
         end
         SETTLE: begin
            if (commit) begin
               state_nxt = VERIFY;
            end else if (settle_timeout) begin
               state_nxt = SEEK_RST;
            end
         end
         VERIFY: begin
            if (verify_fail) begin
               state_nxt = SEEK_RST;
            end else if (verify_done) begin
               state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            locked_o = 1'b1;
            if (lose_lock) begin
               state_nxt = SEEK_RST;
            end
         end
         default: begin
            state_nxt    = SEEK_RST;
            seeker_rst_o = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prev_offset <= 7'd0;
         offset_o    <= 7'd0;
         stable_cnt  <= '0;
         timeout_cnt <= '0;
         good_cnt    <= '0;
         win_cnt     <= '0;
         bad_cnt     <= '0;
      end else begin
         case (state)
            SEEK_RST: begin
               stable_cnt  <= '0;
               timeout_cnt <= '0;
               good_cnt    <= '0;
               win_cnt     <= '0;
               bad_cnt     <= '0;
            end
            SETTLE: begin
               if (buffer_dv_i) begin
                  prev_offset <= seek_offset_i;
                  if (off_match) begin
                     stable_cnt <= (stable_cnt == '1) ? stable_cnt : stable_cnt + 1'b1;
                  end else begin
                     stable_cnt <= '0;
                  end
                  timeout_cnt <= (timeout_cnt == '1) ? timeout_cnt : timeout_cnt + 1'b1;
                  if (commit) begin
                     offset_o <= seek_offset_i;
                  end
               end
            end
            VERIFY: begin
               if (hdr_good) begin
                  good_cnt <= (good_cnt == '1) ? good_cnt : good_cnt + 1'b1;
               end
            end
            LOCKED: begin
               // The last header is judged inside its own window before the clear
               if (hdr_dv_i && !lose_lock) begin
                  if (win_last) begin
                     win_cnt <= '0;
                     bad_cnt <= '0;
                  end else begin
                     win_cnt <= (win_cnt == '1) ? win_cnt : win_cnt + 1'b1;
                     if (hdr_bad) begin
                        bad_cnt <= (bad_cnt == '1) ? bad_cnt : bad_cnt + 1'b1;
                     end
                  end
               end
            end
            default: begin
               stable_cnt <= '0;
            end
         endcase
      end
   end

`ifdef RX_LOCK_CTRL_STATS_EN
   logic [15:0] relock_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         relock_cnt <= 16'h0000;
      end else if (lose_lock && (relock_cnt != 16'hFFFF)) begin
         relock_cnt <= relock_cnt + 16'd1;
      end
   end

   assign relock_cnt_o = relock_cnt;
`else
   assign relock_cnt_o = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rx_lock_ctrl.sv
// ============================================================================
// tb_rx_lock_ctrl : directed table-driven bench for rx_lock_ctrl. Rev 1.0
// ============================================================================
`default_nettype none

module tb_rx_lock_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        buffer_dv_i;
   logic [6:0]  seek_offset_i;
   logic [1:0]  hdr_i;
   logic        hdr_dv_i;
   logic        seeker_rst_o;
   logic [6:0]  offset_o;
   logic        locked_o;
   logic [15:0] relock_cnt_o;

   rx_lock_ctrl dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .buffer_dv_i  (buffer_dv_i),
      .seek_offset_i(seek_offset_i),
      .hdr_i        (hdr_i),
      .hdr_dv_i     (hdr_dv_i),
      .seeker_rst_o (seeker_rst_o),
      .offset_o     (offset_o),
      .locked_o     (locked_o),
      .relock_cnt_o (relock_cnt_o)
   );

   always #5 clk_i = ~clk_i;

`ifdef RX_LOCK_CTRL_STATS_EN
   localparam logic [15:0] RL_STEP = 16'd1;
`else
   localparam logic [15:0] RL_STEP = 16'd0;
`endif

   typedef struct {
      logic        dv;
      logic [6:0]  off;
      logic        hv;
      logic [1:0]  hdr;
      int          n;
      logic        e_rst;
      logic [6:0]  e_off;
      logic        e_lk;
      logic [15:0] e_rl;
   } vec_t;

   vec_t        tbl [10];
   int          n_pass  = 0;
   int          n_total = 0;
   logic [6:0]  exp_off;
   logic [15:0] exp_rl;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outs(input string tag, input logic e_rst, input logic [6:0] e_off,
                             input logic e_lk, input logic [15:0] e_rl);
      chk({tag, ".seeker_rst"}, {31'd0, seeker_rst_o}, {31'd0, e_rst});
      chk({tag, ".offset"},     {25'd0, offset_o},     {25'd0, e_off});
      chk({tag, ".locked"},     {31'd0, locked_o},     {31'd0, e_lk});
      chk({tag, ".relock"},     {16'd0, relock_cnt_o}, {16'd0, e_rl});
   endtask

   task automatic drive(input logic dv, input logic [6:0] off, input logic hv,
                        input logic [1:0] hdr, input int n);
      buffer_dv_i   = dv;
      seek_offset_i = off;
      hdr_dv_i      = hv;
      hdr_i         = hdr;
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Starts from SEEK_RST or SETTLE; one differing strobe makes the run length exact
   task automatic settle_commit(input logic [6:0] off);
      drive(1'b0, 7'd0, 1'b0, 2'b00, 1);
      drive(1'b1, off ^ 7'd1, 1'b0, 2'b00, 1);
      drive(1'b1, off, 1'b0, 2'b00, 15);
      check_outs("settle_hold", 1'b0, exp_off, 1'b0, exp_rl);
      drive(1'b1, off, 1'b0, 2'b00, 1);
      exp_off = off;
      check_outs("commit", 1'b0, exp_off, 1'b0, exp_rl);
   endtask

   task automatic lock_up(input logic [6:0] off);
      settle_commit(off);
      drive(1'b0, off, 1'b1, 2'b01, 31);
      check_outs("verify_hold", 1'b0, exp_off, 1'b0, exp_rl);
      drive(1'b0, off, 1'b1, 2'b10, 1);
      check_outs("lock", 1'b0, exp_off, 1'b1, exp_rl);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0] = '{1'b0, 7'd0,  1'b0, 2'b00, 1,  1'b0, 7'd0,  1'b0, 16'd0};
      tbl[1] = '{1'b1, 7'd37, 1'b0, 2'b00, 15, 1'b0, 7'd0,  1'b0, 16'd0};
      tbl[2] = '{1'b1, 7'd37, 1'b0, 2'b00, 1,  1'b0, 7'd37, 1'b0, 16'd0};
      tbl[3] = '{1'b0, 7'd37, 1'b1, 2'b01, 31, 1'b0, 7'd37, 1'b0, 16'd0};
      tbl[4] = '{1'b0, 7'd37, 1'b1, 2'b10, 1,  1'b0, 7'd37, 1'b1, 16'd0};
      tbl[5] = '{1'b0, 7'd37, 1'b1, 2'b00, 7,  1'b0, 7'd37, 1'b1, 16'd0};
      tbl[6] = '{1'b0, 7'd37, 1'b1, 2'b01, 57, 1'b0, 7'd37, 1'b1, 16'd0};
      tbl[7] = '{1'b0, 7'd37, 1'b1, 2'b11, 7,  1'b0, 7'd37, 1'b1, 16'd0};
      tbl[8] = '{1'b0, 7'd37, 1'b1, 2'b11, 1,  1'b1, 7'd37, 1'b0, RL_STEP};
      tbl[9] = '{1'b0, 7'd37, 1'b0, 2'b00, 1,  1'b0, 7'd37, 1'b0, RL_STEP};

      rst_i         = 1'b1;
      buffer_dv_i   = 1'b0;
      seek_offset_i = 7'd0;
      hdr_i         = 2'b00;
      hdr_dv_i      = 1'b0;
      @(posedge clk_i);
      #1;
      check_outs("reset", 1'b1, 7'd0, 1'b0, 16'd0);
      rst_i = 1'b0;
      chk("release_rst_pulse", {31'd0, seeker_rst_o}, 32'd1);

      // Clean lock at 37, a window with 7 bad kept, then 8 bad in the next window
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].dv, tbl[i].off, tbl[i].hv, tbl[i].hdr, tbl[i].n);
         check_outs($sformatf("vec%0d", i), tbl[i].e_rst, tbl[i].e_off, tbl[i].e_lk, tbl[i].e_rl);
      end
      exp_off = 7'd37;
      exp_rl  = RL_STEP;

      // 8th bad header is the 64th of the window: unlock
      lock_up(7'd21);
      drive(1'b0, 7'd0, 1'b1, 2'b00, 7);
      drive(1'b0, 7'd0, 1'b1, 2'b01, 56);
      check_outs("bnd_a_63", 1'b0, exp_off, 1'b1, exp_rl);
      drive(1'b0, 7'd0, 1'b1, 2'b00, 1);
      exp_rl = exp_rl + RL_STEP;
      check_outs("bnd_a_unlock", 1'b1, exp_off, 1'b0, exp_rl);

      // 7th bad header is the 64th: window clears, lock kept, fresh window counts from zero
      lock_up(7'd50);
      drive(1'b0, 7'd0, 1'b1, 2'b11, 6);
      drive(1'b0, 7'd0, 1'b1, 2'b01, 57);
      drive(1'b0, 7'd0, 1'b1, 2'b00, 1);
      check_outs("bnd_b_wrap", 1'b0, exp_off, 1'b1, exp_rl);
      drive(1'b0, 7'd0, 1'b1, 2'b11, 7);
      check_outs("bnd_b_7bad", 1'b0, exp_off, 1'b1, exp_rl);
      drive(1'b0, 7'd0, 1'b1, 2'b11, 1);
      exp_rl = exp_rl + RL_STEP;
      check_outs("bnd_b_unlock", 1'b1, exp_off, 1'b0, exp_rl);

      // VERIFY failure on header 20
      settle_commit(7'd9);
      drive(1'b0, 7'd0, 1'b1, 2'b01, 19);
      drive(1'b0, 7'd0, 1'b1, 2'b00, 1);
      check_outs("verify_fail", 1'b1, exp_off, 1'b0, exp_rl);
      drive(1'b0, 7'd0, 1'b0, 2'b00, 1);
      check_outs("verify_fail_next", 1'b0, exp_off, 1'b0, exp_rl);

      // Alternating offsets never commit; timeout on strobe 1023
      for (int i = 0; i < 1022; i++) begin
         drive(1'b1, (i % 2 == 0) ? 7'd12 : 7'd13, 1'b0, 2'b00, 1);
      end
      check_outs("alt_1022", 1'b0, exp_off, 1'b0, exp_rl);
      drive(1'b1, 7'd13, 1'b0, 2'b00, 1);
      check_outs("alt_1023", 1'b1, exp_off, 1'b0, exp_rl);
      drive(1'b0, 7'd0, 1'b0, 2'b00, 1);
      check_outs("alt_after", 1'b0, exp_off, 1'b0, exp_rl);

      // Out-of-range offset held constant never commits
      drive(1'b1, 7'd70, 1'b0, 2'b00, 1022);
      check_outs("off70_1022", 1'b0, exp_off, 1'b0, exp_rl);
      drive(1'b1, 7'd70, 1'b0, 2'b00, 1);
      check_outs("off70_1023", 1'b1, exp_off, 1'b0, exp_rl);

      // Asynchronous reset while locked
      lock_up(7'd44);
      #2;
      rst_i = 1'b1;
      #1;
      exp_off = 7'd0;
      exp_rl  = 16'd0;
      check_outs("async_rst", 1'b1, exp_off, 1'b0, exp_rl);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      chk("rerelease_pulse", {31'd0, seeker_rst_o}, 32'd1);
      drive(1'b0, 7'd0, 1'b0, 2'b00, 1);
      check_outs("rerelease_1", 1'b0, exp_off, 1'b0, exp_rl);
      drive(1'b0, 7'd0, 1'b0, 2'b00, 1);
      check_outs("rerelease_2", 1'b0, exp_off, 1'b0, exp_rl);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
